rvh_mmu_miss_arb: RTL and testbench
===================================

Name: rvh_mmu_miss_arb

Overview:
- N-port TLB-miss request arbiter in front of the rvh_ptw translate port; generalises the fixed DTLB/ITLB pair to NUM_REQ requesters.
- Grants requesters with a fair round-robin pointer.
- Records each granted requester's index in an in-order source-tag FIFO and routes each PTW response back to that requester by index, not by access type.
- Limits outstanding translations to MAX_OUTSTANDING.

Parameters:
- NUM_REQ, 2, number of TLB-miss requesters (port 0 = DTLB, port 1 = ITLB by convention).
- MAX_OUTSTANDING, 2, source-tag FIFO depth; power of two, at least 1.
- SRC_W, $clog2(NUM_REQ) with a minimum of 1, requester index width (localparam).
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding-count width (localparam).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- miss_req_vld_i  in  NUM_REQ  per-requester request valid
- miss_req_trans_id_i  in  NUM_REQ*TRANS_ID_WIDTH  packed; slot i = requester i
- miss_req_asid_i  in  NUM_REQ*ASID_WIDTH  packed
- miss_req_vpn_i  in  NUM_REQ*VPN_WIDTH  packed
- miss_req_access_type_i  in  NUM_REQ*2  packed
- miss_req_rdy_o  out  NUM_REQ  one-hot grant-and-accept
- translate_req_vld_o  out  1  to PTW
- translate_req_trans_id_o / _asid_o / _vpn_o / _access_type_o  out  TRANS_ID_WIDTH / ASID_WIDTH / VPN_WIDTH / 2  selected payload
- translate_req_rdy_i  in  1  PTW ready
- translate_resp_vld_i  in  1  PTW response valid; no backpressure
- translate_resp_trans_id_i / _asid_i / _pte_i / _page_lvl_i / _vpn_i / _access_type_i / _access_fault_i / _page_fault_i  in  matching widths  response payload
- miss_resp_vld_o  out  NUM_REQ  one-hot response valid
- miss_resp_* (same eight fields)  out  matching widths  broadcast payload, qualified by miss_resp_vld_o
- outstanding_cnt_o  out  CNT_W  number of tags currently in the FIFO

Behaviour:
- Reset values: rr_ptr=0, FIFO empty, outstanding_cnt_o=0, all vld/rdy outputs 0.
- Grant selection, combinational: first requester with vld set, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
- translate_req_vld_o = (any vld) & ~fifo_full.
- Selected payload is driven to the PTW with zero latency.
- miss_req_rdy_o[g] = granted g & translate_req_rdy_i & ~fifo_full; all other rdy bits are 0.
- Handshake (vld & rdy on the granted port):
  - push g into the tag FIFO;
  - rr_ptr <= (g+1) mod NUM_REQ;
  - rr_ptr holds when there is no handshake. It does not toggle on a conflict alone.
- Requesters must hold vld and payload stable until they see rdy. The arbiter may switch grant while rdy is low only if a higher-priority requester newly asserts.
- Response routing:
  - translate_resp_vld_i -> miss_resp_vld_o[fifo_head] = 1 in the same cycle; all payload fields pass through combinationally.
  - Pop the FIFO the same cycle.
  - PTW responses are strictly in order.
- Boundary conditions:
  - Full: translate_req_vld_o=0 and no rdy, even if a pop occurs that cycle; fullness comes from the registered count.
  - Empty + resp_vld: miss_resp_vld_o=0, response dropped, count stays 0; a simulation assertion fires (protocol error).
  - Push and pop in the same cycle: count is unchanged; head and tail pointers both advance and wrap modulo MAX_OUTSTANDING.
  - NUM_REQ=1: rr_ptr is constant 0.
  - Async reset mid-walk: FIFO and pointer are cleared. Any response arriving after reset is dropped per the empty rule. The PTW must be reset together with this block.

Optional Feature:
- Macro RVH_MMU_ARB_PERF_EN.
- Defined: adds outputs arb_conflict_cnt_o [31:0] and arb_stall_cnt_o [31:0].
  - arb_conflict_cnt_o increments each cycle with two or more vld bits set.
  - arb_stall_cnt_o increments each cycle with any vld set and no handshake.
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/params.vh holds TRANS_ID_WIDTH, ASID_WIDTH, VPN_WIDTH, PTE_WIDTH, PAGE_LVL_WIDTH, and the access-type encodings R=0/W=1/X=2.
- One sub-module, rvh_mmu_src_fifo: a parametrised DEPTH x SRC_W in-order tag FIFO with push, pop, head, full, empty and count, built on DFFRE.
- The round-robin picker stays inline.

Test Plan:
1. After reset: all outputs 0. Single request vld=2'b01 with vpn=0x1234 and translate_req_rdy_i=1 -> rdy_o=01 the same cycle, translate_req_vpn_o=0x1234, count 0->1. Then resp_vld -> miss_resp_vld_o=01, count 1->0.
2. Round-robin: both ports held vld, rdy=1, MAX_OUTSTANDING=4, responses returned each cycle -> grants alternate 0,1,0,1. A response carrying access_type=R for a port-1 request is routed to port 1.
3. Full: MAX_OUTSTANDING=2, two accepted requests with no responses -> translate_req_vld_o=0 and rdy_o=00. A response arrives while vld is still held -> no push that cycle; the push happens the next cycle.
4. Simultaneous push and pop at count=1 -> count stays 1. Run 5 more such cycles so pointers wrap -> responses route in grant order.
5. NUM_REQ=4, vld=4'b1010 with rr_ptr=2 -> port 3 granted, then port 1. Assert rstn low mid-stream -> count 0 and rr_ptr 0 immediately; a later resp_vld produces no miss_resp_vld_o.
6. With RVH_MMU_ARB_PERF_EN: 3 conflict cycles -> arb_conflict_cnt_o=3. Force the counter near 0xFFFFFFFF -> it saturates at all-ones.

Source files
------------

// File: rtl/rvh_mmu_miss_arb_pkg.sv
// Shared widths and access-type encodings for the MMU miss-arbiter slice.
package rvh_mmu_miss_arb_pkg;

  localparam int TRANS_ID_WIDTH = 3;
  localparam int ASID_WIDTH     = 16;
  localparam int VPN_WIDTH      = 27;
  localparam int PTE_WIDTH      = 64;
  localparam int PAGE_LVL_WIDTH = 2;

  typedef enum logic [1:0] {
    ACC_R = 2'd0,
    ACC_W = 2'd1,
    ACC_X = 2'd2
  } access_type_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvh_mmu_miss_arb_chk.sv
// Protocol checker: a PTW response with no outstanding tag is a protocol error.
module rvh_mmu_miss_arb_chk (
  input logic clk,
  input logic rstn,
  input logic resp_vld_i,
  input logic fifo_empty_i
);

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(resp_vld_i && fifo_empty_i))
        else $warning("rvh_mmu_miss_arb: PTW response dropped, no outstanding tag");
    end
  end

endmodule

// File: rtl/rvh_mmu_src_fifo.sv
// In-order source-tag FIFO: one entry per translation in flight, head is the oldest.
module rvh_mmu_src_fifo #(
  parameter int  DEPTH = 2,
  parameter int  W     = 1,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en_s, pop_en_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1'b1);
  endfunction

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign cnt_o     = cnt_q;
  assign push_en_s = push_i & ~full_o;
  assign pop_en_s  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = push_en_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_en_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (push_en_s) begin
      mem_d[wr_ptr_q] = push_data_i;
    end else begin
      mem_d = mem_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rvh_mmu_miss_arb.sv
// Round-robin arbiter funnelling NUM_REQ TLB-miss requesters into one PTW port with in-order routing.
// Defining RVH_MMU_ARB_PERF_EN adds saturating conflict/stall counters.
module rvh_mmu_miss_arb
  import rvh_mmu_miss_arb_pkg::*;
#(
  parameter int  NUM_REQ         = 2,
  parameter int  MAX_OUTSTANDING = 2,
  localparam int SRC_W           = src_w(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_REQ-1:0]                  miss_req_vld_i,
  input  logic [NUM_REQ*TRANS_ID_WIDTH-1:0]   miss_req_trans_id_i,
  input  logic [NUM_REQ*ASID_WIDTH-1:0]       miss_req_asid_i,
  input  logic [NUM_REQ*VPN_WIDTH-1:0]        miss_req_vpn_i,
  input  logic [NUM_REQ*2-1:0]                miss_req_access_type_i,
  output logic [NUM_REQ-1:0]                  miss_req_rdy_o,
  output logic                                translate_req_vld_o,
  output logic [TRANS_ID_WIDTH-1:0]           translate_req_trans_id_o,
  output logic [ASID_WIDTH-1:0]               translate_req_asid_o,
  output logic [VPN_WIDTH-1:0]                translate_req_vpn_o,
  output logic [1:0]                          translate_req_access_type_o,
  input  logic                                translate_req_rdy_i,
  input  logic                                translate_resp_vld_i,
  input  logic [TRANS_ID_WIDTH-1:0]           translate_resp_trans_id_i,
  input  logic [ASID_WIDTH-1:0]               translate_resp_asid_i,
  input  logic [PTE_WIDTH-1:0]                translate_resp_pte_i,
  input  logic [PAGE_LVL_WIDTH-1:0]           translate_resp_page_lvl_i,
  input  logic [VPN_WIDTH-1:0]                translate_resp_vpn_i,
  input  logic [1:0]                          translate_resp_access_type_i,
  input  logic                                translate_resp_access_fault_i,
  input  logic                                translate_resp_page_fault_i,
  output logic [NUM_REQ-1:0]                  miss_resp_vld_o,
  output logic [TRANS_ID_WIDTH-1:0]           miss_resp_trans_id_o,
  output logic [ASID_WIDTH-1:0]               miss_resp_asid_o,
  output logic [PTE_WIDTH-1:0]                miss_resp_pte_o,
  output logic [PAGE_LVL_WIDTH-1:0]           miss_resp_page_lvl_o,
  output logic [VPN_WIDTH-1:0]                miss_resp_vpn_o,
  output logic [1:0]                          miss_resp_access_type_o,
  output logic                                miss_resp_access_fault_o,
  output logic                                miss_resp_page_fault_o,
  output logic [CNT_W-1:0]                    outstanding_cnt_o
`ifdef RVH_MMU_ARB_PERF_EN
  ,
  output logic [31:0]                         arb_conflict_cnt_o,
  output logic [31:0]                         arb_stall_cnt_o
`endif
);

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] gnt_idx_s, cand_idx_s, head_s;
  logic             gnt_vld_s, hs_s, resp_hit_s;
  logic             fifo_full_s, fifo_empty_s;

  // Descending scan so the candidate nearest rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_vld_s  = 1'b0;
    gnt_idx_s  = '0;
    cand_idx_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx_s = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      gnt_idx_s  = miss_req_vld_i[cand_idx_s] ? cand_idx_s : gnt_idx_s;
      gnt_vld_s  = gnt_vld_s | miss_req_vld_i[cand_idx_s];
    end
  end

  assign translate_req_vld_o         = gnt_vld_s & ~fifo_full_s;
  assign hs_s                        = translate_req_vld_o & translate_req_rdy_i;
  assign miss_req_rdy_o              = hs_s ? (NUM_REQ'(1'b1) << gnt_idx_s) : '0;
  assign translate_req_trans_id_o    = miss_req_trans_id_i[int'(gnt_idx_s)*TRANS_ID_WIDTH +: TRANS_ID_WIDTH];
  assign translate_req_asid_o        = miss_req_asid_i[int'(gnt_idx_s)*ASID_WIDTH +: ASID_WIDTH];
  assign translate_req_vpn_o         = miss_req_vpn_i[int'(gnt_idx_s)*VPN_WIDTH +: VPN_WIDTH];
  assign translate_req_access_type_o = miss_req_access_type_i[int'(gnt_idx_s)*2 +: 2];

  // Pointer moves past the winner only on an accepted request.
  always_comb begin
    if (hs_s) begin
      rr_ptr_d = (gnt_idx_s == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + SRC_W'(1'b1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  rvh_mmu_src_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (SRC_W)
  ) u_src_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (hs_s),
    .push_data_i (gnt_idx_s),
    .pop_i       (resp_hit_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .cnt_o       (outstanding_cnt_o)
  );

  // Responses without a tag (e.g. stale after reset) are dropped.
  assign resp_hit_s               = translate_resp_vld_i & ~fifo_empty_s;
  assign miss_resp_vld_o          = resp_hit_s ? (NUM_REQ'(1'b1) << head_s) : '0;
  assign miss_resp_trans_id_o     = translate_resp_trans_id_i;
  assign miss_resp_asid_o         = translate_resp_asid_i;
  assign miss_resp_pte_o          = translate_resp_pte_i;
  assign miss_resp_page_lvl_o     = translate_resp_page_lvl_i;
  assign miss_resp_vpn_o          = translate_resp_vpn_i;
  assign miss_resp_access_type_o  = translate_resp_access_type_i;
  assign miss_resp_access_fault_o = translate_resp_access_fault_i;
  assign miss_resp_page_fault_o   = translate_resp_page_fault_i;

  rvh_mmu_miss_arb_chk u_chk (
    .clk          (clk),
    .rstn         (rstn),
    .resp_vld_i   (translate_resp_vld_i),
    .fifo_empty_i (fifo_empty_s)
  );

`ifdef RVH_MMU_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        conflict_s, stall_s;

  assign conflict_s = ($countones(miss_req_vld_i) > 1);
  assign stall_s    = (|miss_req_vld_i) & ~hs_s;

  // Saturating event counters.
  always_comb begin
    perf_conflict_d = (conflict_s && (perf_conflict_q != 32'hFFFF_FFFF)) ? perf_conflict_q + 32'd1 : perf_conflict_q;
    perf_stall_d    = (stall_s && (perf_stall_q != 32'hFFFF_FFFF)) ? perf_stall_q + 32'd1 : perf_stall_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_conflict_q <= 32'd0;
      perf_stall_q    <= 32'd0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign arb_conflict_cnt_o = perf_conflict_q;
  assign arb_stall_cnt_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_rvh_mmu_miss_arb.sv
// Self-checking bench for rvh_mmu_miss_arb (4 requesters, 2 outstanding): vector table plus scoreboard.
module tb_rvh_mmu_miss_arb;
  import rvh_mmu_miss_arb_pkg::*;

  localparam int NR = 4;
  localparam int NV = 25;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NR-1:0]                req_vld;
  logic [NR*TRANS_ID_WIDTH-1:0] req_tid;
  logic [NR*ASID_WIDTH-1:0]     req_asid;
  logic [NR*VPN_WIDTH-1:0]      req_vpn;
  logic [NR*2-1:0]              req_at;
  logic [NR-1:0]                req_rdy;
  logic                         t_vld, t_rdy;
  logic [TRANS_ID_WIDTH-1:0]    t_tid;
  logic [ASID_WIDTH-1:0]        t_asid;
  logic [VPN_WIDTH-1:0]         t_vpn;
  logic [1:0]                   t_at;
  logic                         r_vld, r_af, r_pf;
  logic [TRANS_ID_WIDTH-1:0]    r_tid;
  logic [ASID_WIDTH-1:0]        r_asid;
  logic [PTE_WIDTH-1:0]         r_pte;
  logic [PAGE_LVL_WIDTH-1:0]    r_lvl;
  logic [VPN_WIDTH-1:0]         r_vpn;
  logic [1:0]                   r_at;
  logic [NR-1:0]                m_vld;
  logic [TRANS_ID_WIDTH-1:0]    m_tid;
  logic [ASID_WIDTH-1:0]        m_asid;
  logic [PTE_WIDTH-1:0]         m_pte;
  logic [PAGE_LVL_WIDTH-1:0]    m_lvl;
  logic [VPN_WIDTH-1:0]         m_vpn;
  logic [1:0]                   m_at;
  logic                         m_af, m_pf;
  logic [1:0]                   cnt;
`ifdef RVH_MMU_ARB_PERF_EN
  logic [31:0]                  conflict_cnt, stall_cnt;
`endif

  rvh_mmu_miss_arb #(.NUM_REQ(NR), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rstn(rstn),
    .miss_req_vld_i(req_vld), .miss_req_trans_id_i(req_tid), .miss_req_asid_i(req_asid),
    .miss_req_vpn_i(req_vpn), .miss_req_access_type_i(req_at), .miss_req_rdy_o(req_rdy),
    .translate_req_vld_o(t_vld), .translate_req_trans_id_o(t_tid), .translate_req_asid_o(t_asid),
    .translate_req_vpn_o(t_vpn), .translate_req_access_type_o(t_at), .translate_req_rdy_i(t_rdy),
    .translate_resp_vld_i(r_vld), .translate_resp_trans_id_i(r_tid), .translate_resp_asid_i(r_asid),
    .translate_resp_pte_i(r_pte), .translate_resp_page_lvl_i(r_lvl), .translate_resp_vpn_i(r_vpn),
    .translate_resp_access_type_i(r_at), .translate_resp_access_fault_i(r_af),
    .translate_resp_page_fault_i(r_pf),
    .miss_resp_vld_o(m_vld), .miss_resp_trans_id_o(m_tid), .miss_resp_asid_o(m_asid),
    .miss_resp_pte_o(m_pte), .miss_resp_page_lvl_o(m_lvl), .miss_resp_vpn_o(m_vpn),
    .miss_resp_access_type_o(m_at), .miss_resp_access_fault_o(m_af),
    .miss_resp_page_fault_o(m_pf), .outstanding_cnt_o(cnt)
`ifdef RVH_MMU_ARB_PERF_EN
    , .arb_conflict_cnt_o(conflict_cnt), .arb_stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] vld;
    logic       rdy;
    logic       resp;
    logic [3:0] exp_rdy;
    logic       exp_tvld;
    logic [1:0] exp_gnt;
  } vec_t;

  vec_t                 vt [NV];
  logic [VPN_WIDTH-1:0] vpn_tab [NR];
  logic [1:0]           at_tab [NR];
  int                   sb [$];
  int                   n_cmp = 0;
  int                   n_err = 0;
  int                   row = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL row%0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    logic [3:0] exp_resp;
    int exp_cnt;

    vpn_tab[0] = 27'h1234; vpn_tab[1] = 27'h2345; vpn_tab[2] = 27'h3456; vpn_tab[3] = 27'h4567;
    at_tab[0] = 2'd1; at_tab[1] = 2'd0; at_tab[2] = 2'd2; at_tab[3] = 2'd0;
    for (int i = 0; i < NR; i++) begin
      req_vpn[i*VPN_WIDTH +: VPN_WIDTH] = vpn_tab[i];
      req_at[i*2 +: 2] = at_tab[i];
      req_tid[i*TRANS_ID_WIDTH +: TRANS_ID_WIDTH] = TRANS_ID_WIDTH'(i);
      req_asid[i*ASID_WIDTH +: ASID_WIDTH] = 16'hA000 + 16'(i);
    end

    // vld, rdy, resp, exp_rdy, exp_tvld, exp_gnt
    vt[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
    vt[2]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    vt[3]  = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[4]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[5]  = '{4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[6]  = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[7]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    vt[8]  = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[9]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
    vt[10] = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1};
    vt[11] = '{4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd1};
    vt[12] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    vt[14] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[15] = '{4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[16] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[17] = '{4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[18] = '{4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[19] = '{4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[20] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
    vt[21] = '{4'b1010, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
    vt[22] = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};
    vt[23] = '{4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[24] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};

    rstn = 1'b0; req_vld = '0; t_rdy = 1'b0; r_vld = 1'b0;
    r_tid = '0; r_asid = '0; r_pte = '0; r_lvl = '0; r_vpn = '0; r_at = '0; r_af = 1'b0; r_pf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_tvld", 64'(t_vld), 64'd0);
    chk("rst_resp_vld", 64'(m_vld), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      row = i;
      req_vld = vt[i].vld; t_rdy = vt[i].rdy; r_vld = vt[i].resp;
      exp_cnt = sb.size();
      exp_resp = 4'b0000;
      r_at = 2'd0;
      if (vt[i].resp && sb.size() > 0) begin
        p = sb.pop_front();
        exp_resp = 4'b0001 << p;
        r_at = at_tab[p];
      end
      r_pte = {$urandom(), $urandom()};
      r_vpn = VPN_WIDTH'($urandom());
      r_pf = 1'($urandom_range(0, 1));
      if (vt[i].exp_rdy != 4'b0000) sb.push_back(int'(vt[i].exp_gnt));
      @(negedge clk);
      chk("req_rdy", 64'(req_rdy), 64'(vt[i].exp_rdy));
      chk("tvld", 64'(t_vld), 64'(vt[i].exp_tvld));
      if (vt[i].exp_tvld) begin
        chk("tvpn", 64'(t_vpn), 64'(vpn_tab[vt[i].exp_gnt]));
        chk("tat", 64'(t_at), 64'(at_tab[vt[i].exp_gnt]));
      end
      chk("cnt", 64'(cnt), 64'(exp_cnt));
      chk("resp_vld", 64'(m_vld), 64'(exp_resp));
      if (vt[i].resp) begin
        chk("resp_pte", m_pte, r_pte);
        chk("resp_vpn", 64'(m_vpn), 64'(r_vpn));
        chk("resp_at", 64'(m_at), 64'(r_at));
        chk("resp_pf", 64'(m_pf), 64'(r_pf));
      end
      @(posedge clk); #1;
    end

    // Async reset mid-stream: one tag outstanding and rr_ptr at 2 beforehand.
    row = 100;
    req_vld = 4'b1111; t_rdy = 1'b0; r_vld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_cnt", 64'(cnt), 64'd0);
    chk("arst_tvld", 64'(t_vld), 64'd1);
    chk("arst_rr_vpn", 64'(t_vpn), 64'(vpn_tab[0]));
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    req_vld = 4'b0000; r_vld = 1'b1;
    @(negedge clk);
    chk("stale_resp_vld", 64'(m_vld), 64'd0);
    chk("stale_cnt", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    r_vld = 1'b0; req_vld = 4'b1111; t_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(req_rdy), 64'b0001);
    chk("post_rst_cnt", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    req_vld = 4'b0000; r_vld = 1'b1;
    @(negedge clk);
    chk("post_rst_cnt1", 64'(cnt), 64'd1);
    chk("post_rst_resp", 64'(m_vld), 64'b0001);
    @(posedge clk); #1;
    r_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_cnt0", 64'(cnt), 64'd0);

`ifdef RVH_MMU_ARB_PERF_EN
    row = 200;
    rstn = 1'b0;
    #1;
    chk("perf_rst_conflict", 64'(conflict_cnt), 64'd0);
    chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    req_vld = 4'b0011; t_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 req_vld = 4'b0000;
    @(negedge clk);
    chk("perf_conflict3", 64'(conflict_cnt), 64'd3);
    chk("perf_stall3", 64'(stall_cnt), 64'd3);
    req_vld = 4'b0011;
    force dut.perf_conflict_q = 32'hFFFF_FFFE;
    #1 release dut.perf_conflict_q;
    repeat (2) @(posedge clk);
    #1 req_vld = 4'b0000;
    @(negedge clk);
    chk("perf_conflict_sat", 64'(conflict_cnt), 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
